mc_ctrl_seq: RTL and testbench

Parametrised multi-cycle control sequencer for the nonpipe MIPS core. It replaces single-cycle timing with a phase FSM: FETCH, DECODE, EXEC, MEM, MD_WAIT, WB, HALT. Instruction and data memories use valid/ack handshakes, and the mult/div unit has a configurable latency. The block takes the instruction-class strobes from the combinational decoder and turns them into per-phase enables, PC update selects and performance counters.

---
 rtl/mc_ctrl_seq.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer for the nonpipe MIPS core.
// Walks each instruction through FETCH/DECODE/EXEC and then MEM, MD_WAIT
// or WB as its class requires. It produces per-phase strobes, the PC source
// select for the retiring instruction, and the cycle and retire counters.
module mc_ctrl_seq #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             im_ack,
  input  logic             dm_ack,
  input  logic             alu_zero,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_beq,
  input  logic             is_bne,
  input  logic             is_jump,
  input  logic             is_jump_reg,
  input  logic             is_md,
  input  logic             is_syscall,
  input  logic             dec_rf_wen,
  output logic             im_req,
  output logic             ir_wen,
  output logic             dm_req,
  output logic             dm_wen,
  output logic             md_start,
  output logic             lhr_wen,
  output logic             rf_wen,
  output logic             pc_wen,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MD_WAIT,
    S_WB,
    S_HALT
  } state_t;

  // MD_WAIT runs for MD_LATENCY cycles, so the count is loaded one short.
  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] sel_now;
  logic [1:0] sel_q;
  logic [7:0] md_cnt;
  logic       sys_retire;

  // PC source code: register jump beats direct jump beats a taken branch.
  function automatic logic [1:0] pc_sel_code(input logic jr, input logic j,
                                             input logic beq, input logic bne,
                                             input logic zero);
    logic take;
    take = (beq & zero) | (bne & ~zero);
    if (jr)
      return 2'b11;
    else if (j)
      return 2'b10;
    else if (take)
      return 2'b01;
    return 2'b00;
  endfunction

  assign sel_now = pc_sel_code(is_jump_reg, is_jump, is_beq, is_bne, alu_zero);

  // Phase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_RST;
    else
      state <= state_nxt;
  end

  // EXEC captures the PC select for a later WB retire and arms the MD counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= 2'b00;
      md_cnt <= 8'd0;
    end else if (state == S_EXEC) begin
      sel_q  <= sel_now;
      md_cnt <= MD_LOAD;
    end else if (state == S_MD_WAIT && md_cnt != 8'd0) begin
      md_cnt <= md_cnt - 8'd1;
    end
  end

  // Next-state and strobe decode; every strobe defaults low.
  always_comb begin
    state_nxt  = state;
    im_req     = 1'b0;
    ir_wen     = 1'b0;
    dm_req     = 1'b0;
    dm_wen     = 1'b0;
    md_start   = 1'b0;
    lhr_wen    = 1'b0;
    rf_wen     = 1'b0;
    pc_wen     = 1'b0;
    pc_sel     = 2'b00;
    halted     = 1'b0;
    sys_retire = 1'b0;
    case (state)
      S_RST: state_nxt = S_FETCH;
      S_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_wen    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_syscall) begin
          sys_retire = 1'b1;
          state_nxt  = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else if (is_md) begin
          md_start  = 1'b1;
          state_nxt = S_MD_WAIT;
        end else if (dec_rf_wen) begin
          state_nxt = S_WB;
        end else begin
          // Branches, J, JR and NOP have nothing left to do after EXEC.
          pc_wen    = 1'b1;
          pc_sel    = sel_now;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_wen = is_store;
        if (dm_ack) begin
          if (is_store) begin
            pc_wen    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_MD_WAIT: begin
        if (md_cnt == 8'd0) begin
          lhr_wen   = 1'b1;
          pc_wen    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        rf_wen    = 1'b1;
        pc_wen    = 1'b1;
        pc_sel    = sel_q;
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_RST;
    endcase
  end

  // Performance counters; HALT freezes the cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_RST && state != S_HALT)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_wen || sys_retire)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Self-checking bench for mc_ctrl_seq. Two instances: MD_LATENCY=4 and 1.
// Expected timing per instruction comes from the class latency table.
module tb_mc_ctrl_seq;

  localparam int K_ALU = 0, K_JAL = 1, K_BEQ = 2, K_BNE = 3, K_J = 4;
  localparam int K_JR = 5, K_NOP = 6, K_LW = 7, K_SW = 8, K_MD = 9, K_SYS = 10;

  logic clk = 1'b0;
  logic rst0, rst1, sel1;
  logic im_ack, dm_ack, alu_zero;
  logic is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen;

  logic a_im_req, a_ir_wen, a_dm_req, a_dm_wen, a_md_start, a_lhr_wen, a_rf_wen, a_pc_wen, a_halted;
  logic b_im_req, b_ir_wen, b_dm_req, b_dm_wen, b_md_start, b_lhr_wen, b_rf_wen, b_pc_wen, b_halted;
  logic [1:0]  a_pc_sel, b_pc_sel;
  logic [31:0] a_cyc, a_ret, b_cyc, b_ret;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cyc   = 0;
  int m_ret   = 0;

  always #5 clk = ~clk;

  mc_ctrl_seq #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst0), .im_ack(im_ack), .dm_ack(dm_ack), .alu_zero(alu_zero),
    .is_load(is_load), .is_store(is_store), .is_beq(is_beq), .is_bne(is_bne),
    .is_jump(is_jump), .is_jump_reg(is_jump_reg), .is_md(is_md), .is_syscall(is_syscall),
    .dec_rf_wen(dec_rf_wen), .im_req(a_im_req), .ir_wen(a_ir_wen), .dm_req(a_dm_req),
    .dm_wen(a_dm_wen), .md_start(a_md_start), .lhr_wen(a_lhr_wen), .rf_wen(a_rf_wen),
    .pc_wen(a_pc_wen), .pc_sel(a_pc_sel), .halted(a_halted), .cycle_cnt(a_cyc),
    .instret_cnt(a_ret)
  );

  mc_ctrl_seq #(.MD_LATENCY(1), .CNT_W(32)) dut_lat1 (
    .clk(clk), .rst(rst1), .im_ack(im_ack), .dm_ack(dm_ack), .alu_zero(alu_zero),
    .is_load(is_load), .is_store(is_store), .is_beq(is_beq), .is_bne(is_bne),
    .is_jump(is_jump), .is_jump_reg(is_jump_reg), .is_md(is_md), .is_syscall(is_syscall),
    .dec_rf_wen(dec_rf_wen), .im_req(b_im_req), .ir_wen(b_ir_wen), .dm_req(b_dm_req),
    .dm_wen(b_dm_wen), .md_start(b_md_start), .lhr_wen(b_lhr_wen), .rf_wen(b_rf_wen),
    .pc_wen(b_pc_wen), .pc_sel(b_pc_sel), .halted(b_halted), .cycle_cnt(b_cyc),
    .instret_cnt(b_ret)
  );

  // Selected instance outputs: {im_req, ir_wen, dm_req, dm_wen, md_start,
  // lhr_wen, rf_wen, pc_wen, pc_sel[1:0], halted}
  logic [10:0] va, vb, ov;
  logic [31:0] o_cyc, o_ret;
  assign va    = {a_im_req, a_ir_wen, a_dm_req, a_dm_wen, a_md_start, a_lhr_wen, a_rf_wen, a_pc_wen, a_pc_sel, a_halted};
  assign vb    = {b_im_req, b_ir_wen, b_dm_req, b_dm_wen, b_md_start, b_lhr_wen, b_rf_wen, b_pc_wen, b_pc_sel, b_halted};
  assign ov    = sel1 ? vb : va;
  assign o_cyc = sel1 ? b_cyc : a_cyc;
  assign o_ret = sel1 ? b_ret : a_ret;

  // Reference tables for each instruction class.
  function automatic int exp_len(input int k, input int imw, input int dmw, input int lat);
    case (k)
      K_ALU, K_JAL:                return imw + 4;
      K_BEQ, K_BNE, K_J, K_JR, K_NOP: return imw + 3;
      K_LW:                        return imw + 5 + dmw;
      K_SW:                        return imw + 4 + dmw;
      K_MD:                        return imw + 3 + lat;
      default:                     return imw + 2;
    endcase
  endfunction

  function automatic int exp_sel(input int k, input bit az);
    case (k)
      K_JR:        return 3;
      K_J, K_JAL:  return 2;
      K_BEQ:       return az ? 1 : 0;
      K_BNE:       return az ? 0 : 1;
      default:     return 0;
    endcase
  endfunction

  // {is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen}
  function automatic logic [8:0] class_bits(input int k);
    case (k)
      K_ALU:   return 9'b000000001;
      K_JAL:   return 9'b000010001;
      K_BEQ:   return 9'b001000000;
      K_BNE:   return 9'b000100000;
      K_J:     return 9'b000010000;
      K_JR:    return 9'b000001000;
      K_LW:    return 9'b100000001;
      K_SW:    return 9'b010000000;
      K_MD:    return 9'b000000100;
      K_SYS:   return 9'b000000010;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic set_rst(input logic v);
    if (sel1) rst1 = v;
    else      rst0 = v;
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    set_rst(1'b1);
    im_ack = 1'b0; dm_ack = 1'b0;
    {is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen} = '0;
    #1;
    n_tests++;
    if (ov !== 11'd0 || o_cyc !== 32'd0 || o_ret !== 32'd0) begin
      n_fail++;
      $display("FAIL %s in_reset: outs=%b cyc=%0d ret=%0d, required all 0", tag, ov, o_cyc, o_ret);
    end
    @(negedge clk);
    set_rst(1'b0);
    im_ack = 1'b1; dm_ack = 1'b1;
    #1;
    n_tests++;
    if (ov !== 11'd0 || o_cyc !== 32'd0) begin
      n_fail++;
      $display("FAIL %s rst_state: outs=%b cyc=%0d, required all 0", tag, ov, o_cyc);
    end
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic run_instr(input int k, input int imw, input int dmw, input bit az, input string tag);
    int len, lat, esel, erf, emd, edm, edmw;
    int n_im, n_ir, n_dm, n_dmw, n_md, n_rf, n_lhr, n_pc, n_ov, n_halt;
    int ir_c, md_c, rf_c, lhr_c, pc_c;
    logic [1:0] sel_seen;
    bit memk;
    lat  = sel1 ? 1 : 4;
    len  = exp_len(k, imw, dmw, lat);
    esel = exp_sel(k, az);
    memk = (k == K_LW || k == K_SW);
    erf  = (k == K_ALU || k == K_JAL || k == K_LW) ? 1 : 0;
    emd  = (k == K_MD) ? 1 : 0;
    edm  = memk ? dmw + 1 : 0;
    edmw = (k == K_SW) ? dmw + 1 : 0;
    n_im = 0; n_ir = 0; n_dm = 0; n_dmw = 0; n_md = 0; n_rf = 0; n_lhr = 0; n_pc = 0;
    n_ov = 0; n_halt = 0;
    ir_c = -1; md_c = -1; rf_c = -1; lhr_c = -1; pc_c = -1; sel_seen = 2'b00;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      im_ack = (c <= imw) ? (c == imw) : 1'($urandom_range(0, 1));
      dm_ack = (memk && c >= imw + 3 && c <= imw + 3 + dmw) ? (c == imw + 3 + dmw)
                                                             : 1'($urandom_range(0, 1));
      {is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen} =
        (c <= imw) ? 9'($urandom) : class_bits(k);
      alu_zero = (c == imw + 2) ? az : 1'($urandom_range(0, 1));
      #1;
      if (c == 0) begin
        n_tests++;
        if (o_cyc !== 32'(m_cyc) || o_ret !== 32'(m_ret)) begin
          n_fail++;
          $display("FAIL %s counters: cycle_cnt=%0d instret_cnt=%0d, required %0d/%0d",
                   tag, o_cyc, o_ret, m_cyc, m_ret);
        end
      end
      if (ov[10]) n_im++;
      if (ov[9])  begin n_ir++; ir_c = c; end
      if (ov[8])  n_dm++;
      if (ov[7])  n_dmw++;
      if (ov[6])  begin n_md++; md_c = c; end
      if (ov[5])  begin n_lhr++; lhr_c = c; end
      if (ov[4])  begin n_rf++; rf_c = c; end
      if (ov[3])  begin n_pc++; pc_c = c; sel_seen = ov[2:1]; end
      if (ov[9] && ov[3]) n_ov++;
      if (ov[0])  n_halt++;
    end
    n_tests++;
    if (n_im != imw + 1 || n_ir != 1 || ir_c != imw) begin
      n_fail++;
      $display("FAIL %s fetch: im_req=%0d ir_wen=%0d@%0d, required %0d/1@%0d", tag, n_im, n_ir, ir_c, imw + 1, imw);
    end
    n_tests++;
    if (n_pc != 1 || pc_c != len - 1 || sel_seen != 2'(esel)) begin
      n_fail++;
      $display("FAIL %s retire: pc_wen=%0d@%0d sel=%0d, required 1@%0d sel=%0d", tag, n_pc, pc_c, sel_seen, len - 1, esel);
    end
    n_tests++;
    if (n_rf != erf || (erf == 1 && rf_c != len - 1)) begin
      n_fail++;
      $display("FAIL %s rf_wen: count=%0d@%0d, required %0d@%0d", tag, n_rf, rf_c, erf, len - 1);
    end
    n_tests++;
    if (n_md != emd || n_lhr != emd || (emd == 1 && (md_c != imw + 2 || lhr_c != len - 1))) begin
      n_fail++;
      $display("FAIL %s muldiv: md_start=%0d@%0d lhr_wen=%0d@%0d, required %0d@%0d %0d@%0d",
               tag, n_md, md_c, n_lhr, lhr_c, emd, imw + 2, emd, len - 1);
    end
    n_tests++;
    if (n_dm != edm || n_dmw != edmw) begin
      n_fail++;
      $display("FAIL %s dmem: dm_req=%0d dm_wen=%0d, required %0d/%0d", tag, n_dm, n_dmw, edm, edmw);
    end
    n_tests++;
    if (n_ov != 0 || n_halt != 0) begin
      n_fail++;
      $display("FAIL %s misc: pc_wen&ir_wen=%0d halted=%0d, required 0/0", tag, n_ov, n_halt);
    end
    m_cyc += len;
    m_ret += 1;
  endtask

  task automatic test_add();
    run_instr(K_ALU, 0, 0, 1'b0, "add");
  endtask

  task automatic test_load();
    run_instr(K_LW, 0, 2, 1'b0, "lw_wait2");
  endtask

  task automatic test_store();
    run_instr(K_SW, 0, 0, 1'b0, "sw");
  endtask

  task automatic test_md();
    run_instr(K_MD, 0, 0, 1'b0, "mult_lat4");
  endtask

  task automatic test_branches();
    run_instr(K_BEQ, 0, 0, 1'b1, "beq_taken");
    run_instr(K_BNE, 0, 0, 1'b1, "bne_not_taken");
    run_instr(K_JR,  0, 0, 1'b0, "jr");
    run_instr(K_JAL, 0, 0, 1'b0, "jal");
    run_instr(K_J,   1, 0, 1'b1, "j");
    run_instr(K_NOP, 0, 0, 1'b0, "nop");
    run_instr(K_BEQ, 2, 0, 1'b0, "beq_not_taken");
    run_instr(K_BNE, 0, 0, 1'b0, "bne_taken");
  endtask

  task automatic test_back_to_back();
    run_instr(K_ALU, 0, 0, 1'b0, "b2b_alu");
    run_instr(K_LW,  0, 0, 1'b0, "b2b_lw");
    run_instr(K_SW,  1, 3, 1'b0, "b2b_sw");
    run_instr(K_ALU, 3, 0, 1'b0, "b2b_alu_slow");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_reset_mid_mem();
    int n_rf;
    n_rf = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      im_ack = (c == 0);
      dm_ack = 1'b0;
      {is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen} =
        (c == 0) ? 9'd0 : class_bits(K_LW);
      #1;
      if (ov[4]) n_rf++;
    end
    n_tests++;
    if (ov[8] !== 1'b1 || ov[7] !== 1'b0 || n_rf != 0) begin
      n_fail++;
      $display("FAIL mid_mem in_mem: dm_req=%b dm_wen=%b rf_wen=%0d, required 1/0/0", ov[8], ov[7], n_rf);
    end
    #2;
    set_rst(1'b1);
    #1;
    n_tests++;
    if (ov !== 11'd0 || o_cyc !== 32'd0 || o_ret !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_mem async_rst: outs=%b cyc=%0d ret=%0d, required all 0", ov, o_cyc, o_ret);
    end
    @(negedge clk);
    set_rst(1'b0);
    im_ack = 1'b1;
    #1;
    n_tests++;
    if (ov !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_mem rst_state: outs=%b, required 0", ov);
    end
    m_cyc = 0;
    m_ret = 0;
    run_instr(K_ALU, 0, 0, 1'b0, "after_rst");
  endtask

  task automatic test_md_lat1();
    rst0 = 1'b1;
    sel1 = 1'b1;
    test_reset("lat1_reset");
    run_instr(K_MD,  0, 0, 1'b0, "mult_lat1");
    run_instr(K_MD,  2, 0, 1'b0, "mult_lat1_slow");
    run_instr(K_ALU, 0, 0, 1'b0, "lat1_add");
  endtask

  task automatic test_syscall(input int imw);
    int n_pc, n_other, first_h;
    n_pc = 0; n_other = 0; first_h = -1;
    for (int c = 0; c < imw + 7; c++) begin
      @(negedge clk);
      im_ack = (c <= imw) ? (c == imw) : 1'($urandom_range(0, 1));
      dm_ack = 1'($urandom_range(0, 1));
      {is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen} =
        (c <= imw) ? 9'($urandom) : class_bits(K_SYS);
      alu_zero = 1'($urandom_range(0, 1));
      #1;
      if (c == 0) begin
        n_tests++;
        if (o_cyc !== 32'(m_cyc) || o_ret !== 32'(m_ret)) begin
          n_fail++;
          $display("FAIL syscall counters_in: cycle_cnt=%0d instret_cnt=%0d, required %0d/%0d",
                   o_cyc, o_ret, m_cyc, m_ret);
        end
      end
      if (ov[0] && first_h < 0) first_h = c;
      if (ov[3]) n_pc++;
      if (c >= imw + 2 && (ov[10:1] !== 10'd0 || ov[0] !== 1'b1)) n_other++;
    end
    n_tests++;
    if (first_h != imw + 2 || n_other != 0) begin
      n_fail++;
      $display("FAIL syscall halt: first halted@%0d bad_halt_cycles=%0d, required @%0d/0", first_h, n_other, imw + 2);
    end
    n_tests++;
    if (n_pc != 0) begin
      n_fail++;
      $display("FAIL syscall pc_wen: count=%0d, required 0", n_pc);
    end
    n_tests++;
    if (o_cyc !== 32'(m_cyc + imw + 2) || o_ret !== 32'(m_ret + 1)) begin
      n_fail++;
      $display("FAIL syscall counters_frozen: cycle_cnt=%0d instret_cnt=%0d, required %0d/%0d",
               o_cyc, o_ret, m_cyc + imw + 2, m_ret + 1);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; sel1 = 1'b0;
    im_ack = 1'b0; dm_ack = 1'b0; alu_zero = 1'b0;
    {is_load, is_store, is_beq, is_bne, is_jump, is_jump_reg, is_md, is_syscall, dec_rf_wen} = '0;
    repeat (3) @(negedge clk);
    test_reset("reset");
    test_add();
    test_load();
    test_store();
    test_md();
    test_branches();
    test_back_to_back();
    test_random();
    test_reset_mid_mem();
    test_syscall(1);
    test_md_lat1();
    test_syscall(0);
    sel1 = 1'b0;
    rst1 = 1'b1;
    test_reset("final_reset");
    run_instr(K_JAL, 1, 0, 1'b0, "final_jal");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
